spi_slave_ctrl: RTL

SPI_SLAVE_CTRL -- requirements
Module: spi_slave_ctrl

---
 rtl/spi_slave_pkg.sv | 48 ++++
 rtl/spi_slave_ctrl_if.sv | 37 +++
 rtl/spi_slave_cmd_decode.sv | 29 ++
 rtl/spi_slave_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
// Shared constants and types for the SPI slave controller: opcodes, FSM states,
// command classes and the shifter target values.
package spi_slave_pkg;

  localparam logic [7:0] OP_WR_REG0 = 8'h01;
  localparam logic [7:0] OP_WR_REG1 = 8'h11;
  localparam logic [7:0] OP_WR_REG2 = 8'h20;
  localparam logic [7:0] OP_WR_REG3 = 8'h30;
  localparam logic [7:0] OP_RD_REG0 = 8'h05;
  localparam logic [7:0] OP_RD_REG1 = 8'h07;
  localparam logic [7:0] OP_RD_REG2 = 8'h21;
  localparam logic [7:0] OP_RD_REG3 = 8'h31;
  localparam logic [7:0] OP_MEM_WR  = 8'h02;
  localparam logic [7:0] OP_MEM_RD  = 8'h0B;

  // Shifter targets are "count minus one": bits-1 in single mode, nibbles-1 in quad.
  localparam logic [7:0] TGT_WORD_SINGLE = 8'd31;
  localparam logic [7:0] TGT_WORD_QUAD   = 8'd7;
  localparam logic [7:0] TGT_BYTE_SINGLE = 8'd7;
  localparam logic [7:0] TGT_BYTE_QUAD   = 8'd1;

  typedef enum logic [2:0] {
    CMD,
    ADDR,
    REG_WR,
    WR_DATA,
    DUMMY,
    TX_DATA,
    IGNORE
  } state_t;

  typedef enum logic [2:0] {
    CLS_REG_WR,
    CLS_REG_RD,
    CLS_MEM_WR,
    CLS_MEM_RD,
    CLS_INVALID
  } cmd_class_t;

  function automatic logic [7:0] word_target(input logic quad);
    return quad ? TGT_WORD_QUAD : TGT_WORD_SINGLE;
  endfunction

  function automatic logic [7:0] byte_target(input logic quad);
    return quad ? TGT_BYTE_QUAD : TGT_BYTE_SINGLE;
  endfunction

endpackage

// File: rtl/spi_slave_ctrl_if.sv
// Bundle between the SPI slave controller, the rx/tx shifters, the config
// registers and the memory port.
interface spi_slave_ctrl_if;
  logic        en_quad_in;
  logic [7:0]  dummy_cycles;
  logic [31:0] rx_data;
  logic        rx_data_ready;
  logic [7:0]  rx_counter;
  logic        rx_counter_upd;
  logic        rx_en_quad;
  logic [7:0]  tx_counter;
  logic        tx_counter_upd;
  logic        tx_en_quad;
  logic        tx_data_ready;
  logic [1:0]  reg_addr;
  logic [7:0]  reg_wdata;
  logic        reg_wr;
  logic        reg_rd;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wr;
  logic        mem_rd;

  modport slave (
    input  en_quad_in, dummy_cycles, rx_data, rx_data_ready, tx_data_ready,
    output rx_counter, rx_counter_upd, rx_en_quad, tx_counter, tx_counter_upd,
           tx_en_quad, reg_addr, reg_wdata, reg_wr, reg_rd,
           mem_addr, mem_wdata, mem_wr, mem_rd
  );

  modport master (
    output en_quad_in, dummy_cycles, rx_data, rx_data_ready, tx_data_ready,
    input  rx_counter, rx_counter_upd, rx_en_quad, tx_counter, tx_counter_upd,
           tx_en_quad, reg_addr, reg_wdata, reg_wr, reg_rd,
           mem_addr, mem_wdata, mem_wr, mem_rd
  );
endinterface

// File: rtl/spi_slave_cmd_decode.sv
// Combinational opcode decode: maps the first received byte to a command class
// and, for register commands, the register index.
module spi_slave_cmd_decode
  import spi_slave_pkg::*;
(
  input  logic [7:0] opcode,
  output cmd_class_t cmd_class,
  output logic [1:0] reg_addr
);

  always_comb begin
    cmd_class = CLS_INVALID;
    reg_addr  = 2'd0;
    case (opcode)
      OP_WR_REG0: begin cmd_class = CLS_REG_WR; reg_addr = 2'd0; end
      OP_WR_REG1: begin cmd_class = CLS_REG_WR; reg_addr = 2'd1; end
      OP_WR_REG2: begin cmd_class = CLS_REG_WR; reg_addr = 2'd2; end
      OP_WR_REG3: begin cmd_class = CLS_REG_WR; reg_addr = 2'd3; end
      OP_RD_REG0: begin cmd_class = CLS_REG_RD; reg_addr = 2'd0; end
      OP_RD_REG1: begin cmd_class = CLS_REG_RD; reg_addr = 2'd1; end
      OP_RD_REG2: begin cmd_class = CLS_REG_RD; reg_addr = 2'd2; end
      OP_RD_REG3: begin cmd_class = CLS_REG_RD; reg_addr = 2'd3; end
      OP_MEM_WR:  cmd_class = CLS_MEM_WR;
      OP_MEM_RD:  cmd_class = CLS_MEM_RD;
      default:    cmd_class = CLS_INVALID;
    endcase
  end

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave protocol controller: sequences command, address, dummy and data
// phases, steering the rx/tx shifter targets and the register/memory strobes.
module spi_slave_ctrl
  import spi_slave_pkg::*;
(
  input  logic            sclk,
  input  logic            cs,
  spi_slave_ctrl_if.slave bus
);

  state_t     state_q, state_d;
  cmd_class_t cmd_q, dec_class;
  logic [1:0] dec_reg_addr;

  logic [7:0] word_tgt, byte_tgt;
  logic [7:0] rx_counter_c, tx_counter_c;
  logic       rx_upd_c, tx_upd_c;
  logic       load_cmd, load_reg_addr, load_addr, inc_addr;
  logic       reg_wr_set, reg_rd_set, mem_wr_set, mem_rd_set;

  logic [31:0] mem_addr_q, mem_wdata_q;
  logic [1:0]  reg_addr_q;
  logic [7:0]  reg_wdata_q;
  logic        reg_wr_q, reg_rd_q, mem_wr_q, mem_rd_q;

  assign word_tgt = word_target(bus.en_quad_in);
  assign byte_tgt = byte_target(bus.en_quad_in);

  spi_slave_cmd_decode u_decode (
    .opcode    (bus.rx_data[7:0]),
    .cmd_class (dec_class),
    .reg_addr  (dec_reg_addr)
  );

  // Shifter targets are Mealy so the next phase is loaded on the very edge that
  // ends the current one; cs suppresses every action in its cycle.
  always_comb begin
    state_d       = state_q;
    rx_counter_c  = 8'd0;
    rx_upd_c      = 1'b0;
    tx_counter_c  = 8'd0;
    tx_upd_c      = 1'b0;
    load_cmd      = 1'b0;
    load_reg_addr = 1'b0;
    load_addr     = 1'b0;
    inc_addr      = 1'b0;
    reg_wr_set    = 1'b0;
    reg_rd_set    = 1'b0;
    mem_wr_set    = 1'b0;
    mem_rd_set    = 1'b0;
    if (!cs) begin
      case (state_q)
        CMD: if (bus.rx_data_ready) begin
          load_cmd = 1'b1;
          case (dec_class)
            CLS_REG_WR: begin
              load_reg_addr = 1'b1;
              rx_upd_c      = 1'b1;
              rx_counter_c  = byte_tgt;
              state_d       = REG_WR;
            end
            CLS_REG_RD: begin
              load_reg_addr = 1'b1;
              reg_rd_set    = 1'b1;
              tx_upd_c      = 1'b1;
              tx_counter_c  = byte_tgt;
              state_d       = TX_DATA;
            end
            CLS_MEM_WR, CLS_MEM_RD: begin
              rx_upd_c     = 1'b1;
              rx_counter_c = word_tgt;
              state_d      = ADDR;
            end
            default: state_d = IGNORE;
          endcase
        end
        REG_WR: if (bus.rx_data_ready) begin
          reg_wr_set = 1'b1;
          state_d    = IGNORE;
        end
        ADDR: if (bus.rx_data_ready) begin
          load_addr = 1'b1;
          if (cmd_q == CLS_MEM_WR) begin
            rx_upd_c     = 1'b1;
            rx_counter_c = word_tgt;
            state_d      = WR_DATA;
          end else begin
            mem_rd_set = 1'b1;
            if (bus.dummy_cycles == 8'd0) begin
              tx_upd_c     = 1'b1;
              tx_counter_c = word_tgt;
              state_d      = TX_DATA;
            end else begin
              rx_upd_c     = 1'b1;
              rx_counter_c = bus.dummy_cycles - 8'd1;
              state_d      = DUMMY;
            end
          end
        end
        WR_DATA: if (bus.rx_data_ready) begin
          mem_wr_set   = 1'b1;
          rx_upd_c     = 1'b1;
          rx_counter_c = word_tgt;
        end
        DUMMY: if (bus.rx_data_ready) begin
          tx_upd_c     = 1'b1;
          tx_counter_c = word_tgt;
          state_d      = TX_DATA;
        end
        TX_DATA: if (bus.tx_data_ready) begin
          if (cmd_q == CLS_MEM_RD) begin
            inc_addr     = 1'b1;
            mem_rd_set   = 1'b1;
            tx_upd_c     = 1'b1;
            tx_counter_c = word_tgt;
          end else begin
            state_d = IGNORE;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Writes advance the address one edge after the mem_wr pulse, reads on the
  // tx edge itself, so each strobe is seen with the address it belongs to.
  always_ff @(posedge sclk) begin
    if (cs) begin
      state_q     <= CMD;
      cmd_q       <= CLS_INVALID;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      reg_addr_q  <= 2'd0;
      reg_wdata_q <= 8'd0;
      reg_wr_q    <= 1'b0;
      reg_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_rd_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      reg_wr_q <= reg_wr_set;
      reg_rd_q <= reg_rd_set;
      mem_wr_q <= mem_wr_set;
      mem_rd_q <= mem_rd_set;
      if (load_cmd)      cmd_q       <= dec_class;
      if (load_reg_addr) reg_addr_q  <= dec_reg_addr;
      if (reg_wr_set)    reg_wdata_q <= bus.rx_data[7:0];
      if (mem_wr_set)    mem_wdata_q <= bus.rx_data;
      if (load_addr)
        mem_addr_q <= bus.rx_data;
      else if (inc_addr || mem_wr_q)
        mem_addr_q <= mem_addr_q + 32'd4;
    end
  end

  assign bus.rx_counter     = rx_counter_c;
  assign bus.rx_counter_upd = rx_upd_c;
  assign bus.rx_en_quad     = bus.en_quad_in;
  assign bus.tx_counter     = tx_counter_c;
  assign bus.tx_counter_upd = tx_upd_c;
  assign bus.tx_en_quad     = bus.en_quad_in;
  assign bus.reg_addr       = reg_addr_q;
  assign bus.reg_wdata      = reg_wdata_q;
  assign bus.reg_wr         = reg_wr_q;
  assign bus.reg_rd         = reg_rd_q;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_wdata      = mem_wdata_q;
  assign bus.mem_wr         = mem_wr_q;
  assign bus.mem_rd         = mem_rd_q;

endmodule
